// File: rtl/csa_resolve.sv
`default_nettype none
// ============================================================================
// csa_resolve : two-stage carry-save (sum + carry<<1) to binary resolver.
// Option: CSA_RESOLVE_SKID_EN adds a 2-entry skid buffer with registered ready.
// Revision: 1.0
// ============================================================================
module csa_resolve (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_s,
  input  logic [63:0] in_c,
  input  logic [2:0]  in_id,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic [2:0]  out_id
);

  localparam int unsigned HALF_W = 32;
  localparam int unsigned PAIR_W = 131;

  logic              src_valid;
  logic [63:0]       src_s;
  logic [63:0]       src_c;
  logic [2:0]        src_id;

  logic              s1_valid_q;
  logic              s1_carry_q;
  logic [HALF_W-1:0] s1_low_q;
  logic [HALF_W-1:0] s1_shi_q;
  logic [HALF_W-1:0] s1_chi_q;
  logic [2:0]        s1_id_q;

  logic              s2_valid_q;
  logic [HALF_W-1:0] hi_q;
  logic [HALF_W-1:0] lo_q;
  logic [2:0]        id_q;

  logic              s2_adv;
  logic              s1_adv;
  logic              s1_load;
  logic              s2_load;
  logic [HALF_W:0]   low_sum_d;
  logic [HALF_W-1:0] hi_sum_d;
  logic              unused_c63;

  assign s2_adv  = !s2_valid_q || out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign s1_load = src_valid && s1_adv && !flush;
  assign s2_load = s1_valid_q && s2_adv && !flush;

  // Carry bit 63 has weight 2^64 and falls off the modulo-2^64 result.
  assign unused_c63 = src_c[63];

`ifdef CSA_RESOLVE_SKID_EN
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              rdy_q;
  logic              accept;
  logic              push;
  logic              pop;
  logic              wr_idx;
  logic [PAIR_W-1:0] sk0_q;
  logic [PAIR_W-1:0] sk1_q;
  logic [PAIR_W-1:0] in_pair;

  // A pair offered while flush is high is killed along with everything else.
  assign in_pair   = {in_id, in_c, in_s};
  assign accept    = in_valid && rdy_q && !flush;
  assign pop       = (cnt_q != 2'd0) && s1_adv;
  assign push      = accept && ((cnt_q != 2'd0) || !s1_adv);
  assign wr_idx    = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);
  assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
  assign in_ready  = rdy_q;
  assign src_valid = (cnt_q != 2'd0) || accept;
  assign {src_id, src_c, src_s} = (cnt_q != 2'd0) ? sk0_q : in_pair;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      sk0_q <= '0;
      sk1_q <= '0;
    end else begin
      cnt_q <= flush ? 2'd0 : cnt_d;
      rdy_q <= flush || (cnt_d != 2'd2);
      if (!flush) begin
        if (pop && (cnt_q == 2'd2)) sk0_q <= sk1_q;
        if (push) begin
          if (wr_idx) sk1_q <= in_pair;
          else        sk0_q <= in_pair;
        end
      end
    end
  end
`else
  logic alive_q;

  assign in_ready  = alive_q && !flush && s1_adv;
  assign src_valid = in_valid && in_ready;
  assign src_s     = in_s;
  assign src_c     = in_c;
  assign src_id    = in_id;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) alive_q <= 1'b0;
    else         alive_q <= 1'b1;
  end
`endif

  assign low_sum_d = {1'b0, src_s[HALF_W-1:0]} + {1'b0, src_c[HALF_W-2:0], 1'b0};
  assign hi_sum_d  = s1_shi_q + s1_chi_q + {{(HALF_W-1){1'b0}}, s1_carry_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_carry_q <= 1'b0;
      s1_low_q   <= '0;
      s1_shi_q   <= '0;
      s1_chi_q   <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      id_q       <= '0;
    end else begin
      s1_valid_q <= flush ? 1'b0 : (s1_adv ? src_valid : s1_valid_q);
      s2_valid_q <= flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
      if (s1_load) begin
        {s1_carry_q, s1_low_q} <= low_sum_d;
        s1_shi_q               <= src_s[63:32];
        s1_chi_q               <= src_c[62:31];
        s1_id_q                <= src_id;
      end
      if (s2_load) begin
        hi_q <= hi_sum_d;
        lo_q <= s1_low_q;
        id_q <= s1_id_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;
  assign out_id    = id_q;

endmodule
`default_nettype wire
